// File: rtl/trace_capture.sv
// trace_capture: first-word-fall-through FIFO of retired-instruction trace records with retire/drop counters
module trace_capture #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trace_en,
  input  logic                       wb_valid,
  input  logic [31:0]                wb_instr,
  input  logic [4:0]                 wb_rd,
  input  logic [4:0]                 wb_rs1,
  input  logic [4:0]                 wb_rs2,
  input  logic [11:0]                wb_imm,
  input  logic                       wb_reg_write,
  input  logic [31:0]                wb_rd_value,
  input  logic                       trace_ready,
  output logic                       trace_valid,
  output logic [31:0]                trace_instruction,
  output logic [4:0]                 trace_rd,
  output logic [4:0]                 trace_rs1,
  output logic [4:0]                 trace_rs2,
  output logic [11:0]                trace_imm,
  output logic [31:0]                trace_rd_value,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [31:0]                retire_count,
  output logic [CNT_W-1:0]           drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [90:0]   mem [DEPTH];
  logic [90:0]   entry, head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          push_req, push, pop, keep;
  assign push_req = trace_en & wb_valid;
  assign pop      = trace_valid & trace_ready;
  assign push     = push_req & ((fifo_level < FULL) | pop);
  assign keep     = wb_reg_write & (wb_rd != 5'd0);
  assign entry    = {wb_instr, keep ? wb_rd : 5'd0, wb_rs1, wb_rs2, wb_imm, keep ? wb_rd_value : 32'd0};
  assign head     = mem[rd_ptr];
  // head record drives the outputs directly, forced to zero when the FIFO is empty
  always_comb begin
    trace_valid       = fifo_level != '0;
    trace_instruction = trace_valid ? head[90:59] : '0;
    trace_rd          = trace_valid ? head[58:54] : '0;
    trace_rs1         = trace_valid ? head[53:49] : '0;
    trace_rs2         = trace_valid ? head[48:44] : '0;
    trace_imm         = trace_valid ? head[43:32] : '0;
    trace_rd_value    = trace_valid ? head[31:0]  : '0;
  end
  // storage array needs no reset since outputs are gated by trace_valid
  always_ff @(posedge clk)
    if (rst_n && push) mem[wr_ptr] <= entry;
  // pointers, occupancy and counters; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fifo_level   <= '0;
      retire_count <= '0;
      drop_count   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level   <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      retire_count <= retire_count + 32'(push);
      if (push_req && !push && !(&drop_count)) drop_count <= drop_count + 1'b1;
    end
  end
endmodule
